// File: rtl/computer_pkg.sv
// rtl/computer_pkg.sv - constants and loader state/flag types shared by the loader and memory
package computer_pkg;

  localparam int         DEF_DEPTH     = 16;
  localparam int         DEF_ADDR_W    = 4;
  localparam int         DEF_DATA_W    = 8;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int         DEF_TIMEOUT   = 50_000_000;

  typedef enum logic [2:0] {
    IDLE, SYNC, COUNT, DATA, WRITE, CHECK, DONE, ERROR
  } loader_state_t;

  typedef struct packed {
    logic rx_ready;
    logic prog;
    logic cpu_rst;
    logic busy;
    logic done;
    logic err;
  } loader_flags_t;

  // Output levels that hold for the whole time the loader sits in state s.
  function automatic loader_flags_t flags_of(loader_state_t s);
    loader_flags_t f;
    f          = '0;
    f.busy     = !(s inside {IDLE, DONE, ERROR});
    f.rx_ready = s inside {SYNC, COUNT, DATA, CHECK};
    f.prog     = f.busy;
    f.cpu_rst  = f.busy || (s == ERROR);
    f.done     = (s == DONE);
    f.err      = (s == ERROR);
    return f;
  endfunction

endpackage

// File: rtl/loader_watchdog.sv
// rtl/loader_watchdog.sv - idle-cycle counter that flags a stalled frame
module loader_watchdog #(
  parameter int TIMEOUT = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fires on the TIMEOUT-th consecutive enabled cycle without a clear.
  assign expired = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - frames a byte stream into RAM writes through the manual-programming port
module program_loader
  import computer_pkg::*;
#(
  parameter int                DEPTH     = DEF_DEPTH,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(DEF_SYNC_BYTE),
  parameter int                TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] manual_addr,
  output logic [DATA_W-1:0] manual_value,
  output logic              manual_WE,
  output logic              PROG,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [DATA_W:0] DEPTH_V = (DATA_W + 1)'(DEPTH);

  loader_state_t     state;
  loader_flags_t     flags;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] csum;
  logic              accept;
  logic              wd_en;
  logic              wd_expired;

  assign accept = rx_valid && rx_ready;
  assign wd_en  = state inside {COUNT, DATA, CHECK};
  assign {rx_ready, PROG, cpu_rst, busy, done, err} = flags;

  loader_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept || !wd_en),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  // Flags are loaded together with the state so every output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      flags        <= '0;
      addr_cnt     <= '0;
      last_addr    <= '0;
      csum         <= '0;
      manual_addr  <= '0;
      manual_value <= '0;
      manual_WE    <= 1'b0;
    end else begin
      manual_WE <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state <= SYNC;
            flags <= flags_of(SYNC);
          end
        end
        SYNC: begin
          if (accept && rx_data == SYNC_BYTE) begin
            state <= COUNT;
            flags <= flags_of(COUNT);
          end
        end
        COUNT: begin
          if (accept) begin
            if (rx_data == '0 || {1'b0, rx_data} > DEPTH_V) begin
              state <= ERROR;
              flags <= flags_of(ERROR);
            end else begin
              last_addr <= ADDR_W'(rx_data - DATA_W'(1));
              addr_cnt  <= '0;
              csum      <= '0;
              state     <= DATA;
              flags     <= flags_of(DATA);
            end
          end else if (wd_expired) begin
            state <= ERROR;
            flags <= flags_of(ERROR);
          end
        end
        DATA: begin
          if (accept) begin
            manual_value <= rx_data;
            manual_addr  <= addr_cnt;
            manual_WE    <= 1'b1;
            csum         <= csum + rx_data;
            state        <= WRITE;
            flags        <= flags_of(WRITE);
          end else if (wd_expired) begin
            state <= ERROR;
            flags <= flags_of(ERROR);
          end
        end
        WRITE: begin
          // The counter only advances when another word follows, so it never wraps.
          if (addr_cnt == last_addr) begin
            state <= CHECK;
            flags <= flags_of(CHECK);
          end else begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            state    <= DATA;
            flags    <= flags_of(DATA);
          end
        end
        CHECK: begin
          if (accept) begin
            state <= (rx_data == csum) ? DONE : ERROR;
            flags <= flags_of((rx_data == csum) ? DONE : ERROR);
          end else if (wd_expired) begin
            state <= ERROR;
            flags <= flags_of(ERROR);
          end
        end
        default: begin
          state <= IDLE;
          flags <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized bench for program_loader against a frame-level reference model
module tb_program_loader;

  localparam int TB_TIMEOUT = 40;

  typedef logic [7:0] bq_t[$];

  logic       clk;
  logic       rst;
  logic       start;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [3:0] manual_addr;
  logic [7:0] manual_value;
  logic       manual_WE;
  logic       PROG;
  logic       cpu_rst;
  logic       busy;
  logic       done;
  logic       err;

  int          checks;
  int          errors;
  int          acc_cnt;
  bit          chk_en;
  bit          exp_busy;
  bit          exp_done;
  bit          exp_err;
  logic [11:0] exp_wq[$];
  logic [7:0]  exp_ram[16];
  logic [7:0]  dut_ram[16];

  program_loader #(
    .DEPTH     (16),
    .ADDR_W    (4),
    .DATA_W    (8),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .manual_addr  (manual_addr),
    .manual_value (manual_value),
    .manual_WE    (manual_WE),
    .PROG         (PROG),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench stopped");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of the DUT against the model's expected flags and write sequence.
  task automatic compare_loop();
    logic [11:0] w;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (rx_valid && rx_ready) acc_cnt++;
        if (manual_WE) begin
          if (exp_wq.size() == 0) begin
            check("unexpected_write", {manual_addr, manual_value}, 0);
          end else begin
            w = exp_wq.pop_front();
            check("we_addr", manual_addr, w[11:8]);
            check("we_value", manual_value, w[7:0]);
          end
          check("we_rx_ready", rx_ready, 0);
          if (PROG) dut_ram[manual_addr] = manual_value;
        end
        if (!exp_busy) check("idle_rx_ready", rx_ready, 0);
        check("flags_busy_prog_cpurst_done_err", {busy, PROG, cpu_rst, done, err},
              {exp_busy, exp_busy, exp_busy | exp_err, exp_done, exp_err});
      end
    end
  endtask

  // Frame-level reference: which words get written and whether the load succeeds.
  task automatic model_frame(input bq_t fr, output bit good);
    int         i;
    int         n;
    logic [7:0] cs;
    i  = 0;
    cs = 8'h00;
    while (i < fr.size() && fr[i] != 8'hA5) i++;
    i++;
    n = int'(fr[i]);
    i++;
    if (n == 0 || n > 16) begin
      good = 1'b0;
      return;
    end
    for (int k = 0; k < n; k++) begin
      exp_wq.push_back({4'(k), fr[i]});
      exp_ram[k] = fr[i];
      cs = cs + fr[i];
      i++;
    end
    good = (fr[i] == cs);
  endtask

  task automatic arm();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    bit ok;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
        start = noise & 1'($urandom);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    ok       = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk); #1;
      start = ok ? 1'b0 : (noise & 1'($urandom));
    end
    if (!ok) check("rx_accept_timeout", 0, 1);
  endtask

  task automatic run_frame(input bq_t fr, input int gmax, input bit noise, output bit good);
    int acc0;
    model_frame(fr, good);
    acc0 = acc_cnt;
    if (gmax == 0) begin
      rx_valid = 1'b1;
      rx_data  = fr[0];
    end
    arm();
    exp_busy = 1'b1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    foreach (fr[i]) send_byte(fr[i], (gmax > 0) ? $urandom_range(0, gmax) : 0, noise);
    rx_valid = 1'b0;
    exp_busy = 1'b0;
    exp_done = good;
    exp_err  = !good;
    @(negedge clk);
    check("frame_bytes_accepted", acc_cnt - acc0, fr.size());
    check("frame_writes_drained", exp_wq.size(), 0);
    for (int a = 0; a < 16; a++) check($sformatf("ram_%0d", a), dut_ram[a], exp_ram[a]);
    @(posedge clk); #1;
  endtask

  initial begin
    bq_t        fr;
    bit         good;
    int         n;
    logic [7:0] cs;
    logic [7:0] d;

    checks   = 0;
    errors   = 0;
    acc_cnt  = 0;
    chk_en   = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    for (int a = 0; a < 16; a++) begin
      exp_ram[a] = 8'h00;
      dut_ram[a] = 8'h00;
    end
    fork
      compare_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_prog", PROG, 0);
    check("reset_cpu_rst", cpu_rst, 0);
    check("reset_done_err", {done, err}, 0);
    check("reset_rx_ready", rx_ready, 0);
    check("reset_we_addr_value", {manual_WE, manual_addr, manual_value}, 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Good load of three words.
    fr = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    run_frame(fr, 1, 1'b0, good);
    check("s1_model_good", good, 1);
    check("s1_ram0", dut_ram[0], 8'h11);
    check("s1_ram1", dut_ram[1], 8'h22);
    check("s1_ram2", dut_ram[2], 8'h33);
    check("s1_done_cpu_rst", {done, cpu_rst}, 2'b10);

    // Bad checksum, then start recovers to SYNC.
    fr = {8'hA5, 8'h02, 8'h01, 8'h02, 8'h04};
    run_frame(fr, 1, 1'b0, good);
    check("s2_err_cpu_rst", {err, cpu_rst}, 2'b11);
    check("s2_ram0", dut_ram[0], 8'h01);
    check("s2_ram1", dut_ram[1], 8'h02);
    arm();
    exp_busy = 1'b1;
    exp_err  = 1'b0;
    @(negedge clk);
    check("s2_recover_sync", {busy, rx_ready, err}, 3'b110);
    @(posedge clk); #1;

    // Count byte out of range.
    fr = {8'hA5, 8'h00};
    run_frame(fr, 1, 1'b0, good);
    check("s3_count0_err", err, 1);
    fr = {8'hA5, 8'h11};
    run_frame(fr, 1, 1'b0, good);
    check("s3_count17_err", err, 1);

    // Garbage before sync, full-depth image, rx_valid held high throughout.
    fr = {8'h00, 8'hFF, 8'hA5, 8'h10};
    for (int k = 1; k <= 16; k++) fr.push_back(8'(k));
    fr.push_back(8'h88);
    run_frame(fr, 0, 1'b0, good);
    check("s3_full_done", done, 1);
    check("s3_ram15", dut_ram[15], 8'h10);

    // Scenario 1 replayed with start pulses while busy.
    fr = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    run_frame(fr, 2, 1'b1, good);
    check("s6_done", done, 1);
    check("s6_ram2", dut_ram[2], 8'h33);
    check("s6_partial_ram3", dut_ram[3], 8'h04);

    // Stall after the count byte.
    arm();
    exp_busy = 1'b1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h03, 0, 1'b0);
    rx_valid = 1'b0;
    repeat (TB_TIMEOUT) begin
      @(posedge clk); #1;
    end
    exp_busy = 1'b0;
    exp_err  = 1'b1;
    @(negedge clk);
    check("timeout_err", {err, cpu_rst}, 2'b11);
    @(posedge clk); #1;

    // Reset after the second data byte.
    arm();
    exp_busy = 1'b1;
    exp_err  = 1'b0;
    exp_wq.push_back({4'd0, 8'hAA});
    exp_wq.push_back({4'd1, 8'hBB});
    exp_ram[0] = 8'hAA;
    exp_ram[1] = 8'hBB;
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    rx_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    exp_busy = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check("midrst_flags", {busy, PROG, cpu_rst, done, err, rx_ready}, 0);
    check("midrst_port", {manual_WE, manual_addr, manual_value}, 0);
    check("midrst_ram0", dut_ram[0], 8'hAA);
    check("midrst_ram1", dut_ram[1], 8'hBB);
    check("midrst_ram2", dut_ram[2], 8'h33);
    check("midrst_writes", exp_wq.size(), 0);
    @(posedge clk); #1;

    // Randomized frames.
    for (int f = 0; f < 24; f++) begin
      fr = {};
      repeat ($urandom_range(0, 2)) begin
        d = 8'($urandom);
        if (d == 8'hA5) d = 8'h5A;
        fr.push_back(d);
      end
      fr.push_back(8'hA5);
      if ($urandom_range(0, 9) == 0) begin
        fr.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
      end else begin
        n  = $urandom_range(1, 16);
        cs = 8'h00;
        fr.push_back(8'(n));
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          fr.push_back(d);
          cs = cs + d;
        end
        if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
        fr.push_back(cs);
      end
      run_frame(fr, $urandom_range(0, 2), 1'($urandom_range(0, 1)), good);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
